host_link_encoder: RTL and testbench

Host-side counterpart of the TPU's byte-stream link. Serializes one board position (grid plus candidate-move list) into the framed byte stream the TPU's grid decoder consumes. Then waits for the TPU's two-byte optimal-move reply and reassembles it into a 16-bit move. Used as the stimulus and driver end in system benches and in the FPGA host bridge.

---
 rtl/host_link_pkg.sv | 27 ++
 rtl/move_buffer.sv | 25 ++
 rtl/host_link_encoder.sv | 189 ++++++++++++++++++
 tb/tb_host_link_encoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/host_link_pkg.sv
// Shared types and constants for the host-side byte-stream link encoder.
package host_link_pkg;

  localparam logic [7:0] GRID_HEADER_DEF = 8'b11_01_01_01;
  localparam logic [7:0] MOVE_HEADER_DEF = 8'b11_10_10_10;

  // Grid header, move header and count byte surround the cell and move payload.
  localparam int FRAME_HDR_BYTES = 3;
  localparam int MOVE_BYTES      = 2;

  typedef enum logic [3:0] {
    IDLE,
    SEND_GHDR,
    SEND_GRID,
    SEND_MHDR,
    SEND_CNT,
    MOVE_HI,
    MOVE_LO,
    WAIT_HI,
    WAIT_LO
  } link_state_t;

  function automatic int frame_len(input int cells, input int count);
    return FRAME_HDR_BYTES + cells + MOVE_BYTES * count;
  endfunction

endpackage

// File: rtl/move_buffer.sv
// Candidate-move RAM: one write port, registered read port with read-before-write.
module move_buffer #(
  parameter int DEPTH = 220,
  parameter int DW    = 16,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/host_link_encoder.sv
// Serializes a board position into the TPU link frame and reassembles the
// two-byte optimal-move reply, with a timeout on the first reply byte.
module host_link_encoder
  import host_link_pkg::*;
#(
  parameter int                    WIDTH        = 8,
  parameter int                    HEIGHT       = 8,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    MOVE_WIDTH   = 16,
  parameter int                    MAX_MOVES    = 220,
  parameter logic [DATA_WIDTH-1:0] GRID_HEADER  = DATA_WIDTH'(GRID_HEADER_DEF),
  parameter logic [DATA_WIDTH-1:0] MOVE_HEADER  = DATA_WIDTH'(MOVE_HEADER_DEF),
  parameter int                    RESP_TIMEOUT = 4096
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] grid_id,
  input  logic [7:0]                         total_moves,
  input  logic                               move_we,
  input  logic [7:0]                         move_waddr,
  input  logic [MOVE_WIDTH-1:0]              move_wd,
  output logic                               busy,
  output logic                               tx_ov,
  output logic [DATA_WIDTH-1:0]              tx_od,
  input  logic                               tx_ready,
  input  logic                               rx_iv,
  input  logic [DATA_WIDTH-1:0]              rx_id,
  output logic                               result_ov,
  output logic [MOVE_WIDTH-1:0]              result_od,
  output logic                               timeout_o
);

  localparam int         CELLS   = HEIGHT * WIDTH;
  localparam int         CW      = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int         TW      = $clog2(RESP_TIMEOUT + 1);
  localparam logic [7:0] MAX_CNT = 8'(MAX_MOVES);

  link_state_t           state_q, state_d;
  logic [CW-1:0]         cell_q, cell_d;
  logic [7:0]            move_q, move_d;
  logic [7:0]            cnt_q;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] grid_q [CELLS];
  logic [DATA_WIDTH-1:0] rx_hi_q;
  logic [MOVE_WIDTH-1:0] result_q;
  logic                  result_ov_q, timeout_q;
  logic                  ovr_vld_q, ovr_cap_q;
  logic [7:0]            ovr_addr_q;
  logic [MOVE_WIDTH-1:0] ovr_data_q;
  logic [MOVE_WIDTH-1:0] rd_data, move_word;
  logic [7:0]            rd_addr;
  logic                  start_ok, wr_ok, tmo_hit, reply_done;

  assign start_ok   = start && (state_q == IDLE);
  assign wr_ok      = move_we && (state_q == IDLE) && (move_waddr < MAX_CNT);
  assign tmo_hit    = (state_q == WAIT_HI) && !rx_iv && (tmo_q == TW'(RESP_TIMEOUT - 1));
  assign reply_done = (state_q == WAIT_LO) && rx_iv;

  // In IDLE the read port samples the write address so a write colliding with
  // start can be shadowed by its old value; otherwise it prefetches the next move.
  assign rd_addr = (state_q == IDLE) ? move_waddr : move_d;

  move_buffer #(
    .DEPTH (MAX_MOVES),
    .DW    (MOVE_WIDTH),
    .AW    (8)
  ) u_move_buffer (
    .clk       (clk),
    .wr_en_i   (wr_ok),
    .wr_addr_i (move_waddr),
    .wr_data_i (move_wd),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign move_word = (ovr_vld_q && (ovr_addr_q == move_q)) ? ovr_data_q : rd_data;

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    move_d  = move_q;
    tmo_d   = '0;
    tx_ov   = 1'b0;
    tx_od   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND_GHDR;
          cell_d  = '0;
          move_d  = '0;
        end
      end
      SEND_GHDR: begin
        tx_ov = 1'b1;
        tx_od = GRID_HEADER;
        if (tx_ready) state_d = SEND_GRID;
      end
      SEND_GRID: begin
        tx_ov = 1'b1;
        tx_od = grid_q[cell_q];
        if (tx_ready) begin
          if (cell_q == CW'(CELLS - 1)) state_d = SEND_MHDR;
          else                          cell_d  = cell_q + 1'b1;
        end
      end
      SEND_MHDR: begin
        tx_ov = 1'b1;
        tx_od = MOVE_HEADER;
        if (tx_ready) state_d = SEND_CNT;
      end
      SEND_CNT: begin
        tx_ov = 1'b1;
        tx_od = DATA_WIDTH'(cnt_q);
        if (tx_ready) state_d = (cnt_q == 8'd0) ? WAIT_HI : MOVE_HI;
      end
      MOVE_HI: begin
        tx_ov = 1'b1;
        tx_od = move_word[MOVE_WIDTH-1 -: DATA_WIDTH];
        if (tx_ready) state_d = MOVE_LO;
      end
      MOVE_LO: begin
        tx_ov = 1'b1;
        tx_od = move_word[DATA_WIDTH-1:0];
        if (tx_ready) begin
          if (move_q + 8'd1 == cnt_q) begin
            state_d = WAIT_HI;
          end else begin
            move_d  = move_q + 8'd1;
            state_d = MOVE_HI;
          end
        end
      end
      WAIT_HI: begin
        if (rx_iv)        state_d = WAIT_LO;
        else if (tmo_hit) state_d = IDLE;
        else              tmo_d   = tmo_q + 1'b1;
      end
      WAIT_LO: begin
        if (rx_iv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cell_q      <= '0;
      move_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      result_q    <= '0;
      result_ov_q <= 1'b0;
      timeout_q   <= 1'b0;
      ovr_vld_q   <= 1'b0;
      ovr_cap_q   <= 1'b0;
      ovr_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cell_q      <= cell_d;
      move_q      <= move_d;
      tmo_q       <= tmo_d;
      result_ov_q <= reply_done;
      timeout_q   <= tmo_hit;
      ovr_cap_q   <= start_ok;
      if (start_ok) begin
        cnt_q      <= (total_moves > MAX_CNT) ? MAX_CNT : total_moves;
        ovr_vld_q  <= wr_ok;
        ovr_addr_q <= move_waddr;
      end
      if (reply_done) result_q <= {rx_hi_q, rx_id};
    end
  end

  always_ff @(posedge clk) begin
    if (start_ok) begin
      for (int i = 0; i < CELLS; i++) grid_q[i] <= grid_id[i*DATA_WIDTH +: DATA_WIDTH];
    end
    if (ovr_cap_q) ovr_data_q <= rd_data;
    if ((state_q == WAIT_HI) && rx_iv) rx_hi_q <= rx_id;
  end

  assign busy      = (state_q != IDLE);
  assign result_ov = result_ov_q;
  assign result_od = result_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_host_link_encoder.sv
// Scoreboard bench for host_link_encoder: table-driven frames plus corner sequences.
module tb_host_link_encoder;

  localparam int W = 8, H = 8, DW = 8, MW = 16, MAXM = 220, RT = 4096;

  logic              clk = 1'b0;
  logic              rst, start, move_we, tx_ready, rx_iv;
  logic [H*W*DW-1:0] grid_id;
  logic [7:0]        total_moves, move_waddr;
  logic [MW-1:0]     move_wd, result_od;
  logic              busy, tx_ov, result_ov, timeout_o;
  logic [DW-1:0]     tx_od, rx_id;

  always #5 clk = ~clk;

  host_link_encoder #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .MOVE_WIDTH(MW), .MAX_MOVES(MAXM),
    .GRID_HEADER(8'hD5), .MOVE_HEADER(8'hEA), .RESP_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .grid_id(grid_id), .total_moves(total_moves),
    .move_we(move_we), .move_waddr(move_waddr), .move_wd(move_wd), .busy(busy),
    .tx_ov(tx_ov), .tx_od(tx_od), .tx_ready(tx_ready), .rx_iv(rx_iv), .rx_id(rx_id),
    .result_ov(result_ov), .result_od(result_od), .timeout_o(timeout_o)
  );

  typedef struct {
    int         total;
    int         rmode;
    logic [7:0] key;
    logic [7:0] exp_cnt;
    logic [7:0] rhi;
    logic [7:0] rlo;
    logic [15:0] exp_res;
  } vec_t;

  vec_t        vecs[8];
  logic [7:0]  exp_q[$];
  logic [15:0] mv[MAXM];
  int          total = 0, bad = 0;
  int          rmode = 0, res_seen = 0, tmo_seen = 0;
  logic        s_txov, s_busy, s_resov, s_tmo, held_vld = 1'b0;
  logic [7:0]  s_txod, held_b;
  logic [15:0] last_exp = 16'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    s_txov = tx_ov; s_busy = busy; s_resov = result_ov; s_tmo = timeout_o; s_txod = tx_od;
    if (tx_ov && held_vld) check("tx_hold", 32'(tx_od), 32'(held_b));
    if (tx_ov && tx_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_extra: got byte %0h, expected none", tx_od);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", 32'(tx_od), 32'(e));
      end
    end
    held_vld = tx_ov && !tx_ready;
    held_b   = tx_od;
    if (result_ov === 1'b1) begin res_seen++; check("busy_at_result", 32'(busy), 32'd0); end
    if (timeout_o === 1'b1) begin tmo_seen++; check("busy_at_timeout", 32'(busy), 32'd0); end
    @(posedge clk); #1;
    tx_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic begin_frame(input vec_t v, input bit coll, input int caddr, input logic [15:0] cdata);
    rmode = v.rmode;
    for (int i = 0; i < H*W; i++) grid_id[i*DW +: DW] = 8'(i) ^ v.key;
    total_moves = 8'(v.total);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < H*W; i++) exp_q.push_back(8'(i) ^ v.key);
    exp_q.push_back(8'hEA);
    exp_q.push_back(v.exp_cnt);
    for (int m = 0; m < int'(v.exp_cnt); m++) begin
      exp_q.push_back(mv[m][15:8]);
      exp_q.push_back(mv[m][7:0]);
    end
    if (coll) begin move_we = 1'b1; move_waddr = 8'(caddr); move_wd = cdata; end
    start = 1'b1;
    tick();
    start = 1'b0; move_we = 1'b0;
    if (coll) mv[caddr] = cdata;
  endtask

  task automatic run_frame(input vec_t v, input bit coll, input int caddr, input logic [15:0] cdata, input bit poke);
    int n = 0;
    begin_frame(v, coll, caddr, cdata);
    do begin
      if (poke && n == 20) begin
        start = 1'b1; move_we = 1'b1; move_waddr = 8'd1; move_wd = 16'hDEAD;
      end
      tick();
      n++;
      start = 1'b0; move_we = 1'b0;
      if (n == 1) check("tx_ov_rise", 32'(s_txov), 32'd1);
    end while (exp_q.size() != 0 && n < 5000);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL frame_stall: %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    if (v.rmode == 0) check("frame_len", 32'(n), 32'(1 + H*W + 1 + 1 + 2*int'(v.exp_cnt)));
  endtask

  task automatic do_reply(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp);
    int r0 = res_seen;
    rx_iv = 1'b1; rx_id = hi;
    tick();
    check("wait_tx_ov_low", 32'(s_txov), 32'd0);
    check("wait_busy", 32'(s_busy), 32'd1);
    rx_id = lo;
    tick();
    rx_iv = 1'b0; rx_id = 8'h00;
    tick();
    check("result_ov_pulse", 32'(s_resov), 32'd1);
    check("result_od", 32'(result_od), 32'(exp));
    tick(); tick();
    check("result_count", 32'(res_seen - r0), 32'd1);
    last_exp = exp;
  endtask

  initial begin
    int i;
    int r0;
    vec_t vc;
    rst = 1'b1; start = 1'b0; move_we = 1'b0; move_waddr = '0; move_wd = '0;
    tx_ready = 1'b1; rx_iv = 1'b0; rx_id = '0; grid_id = '0; total_moves = '0;

    vecs[0] = '{2,   0, 8'h00, 8'h02, 8'h0C, 8'h1F, 16'h0C1F};
    vecs[1] = '{0,   0, 8'h5A, 8'h00, 8'h55, 8'hAA, 16'h55AA};
    vecs[2] = '{250, 0, 8'h00, 8'hDC, 8'h12, 8'h34, 16'h1234};
    vecs[3] = '{2,   1, 8'h00, 8'h02, 8'h0C, 8'h1F, 16'h0C1F};
    vecs[4] = '{7,   1, 8'hC3, 8'h07, 8'hFE, 8'h01, 16'hFE01};
    vecs[5] = '{220, 1, 8'h11, 8'hDC, 8'h80, 8'h00, 16'h8000};
    vecs[6] = '{221, 0, 8'hFF, 8'hDC, 8'h00, 8'hFF, 16'h00FF};
    vecs[7] = '{219, 1, 8'h3C, 8'hDB, 8'hA5, 8'h5A, 16'hA55A};

    tick(); tick();
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_tx_ov", 32'(s_txov), 32'd0);
    check("rst_tx_od", 32'(s_txod), 32'd0);
    check("rst_result_ov", 32'(s_resov), 32'd0);
    check("rst_timeout", 32'(s_tmo), 32'd0);
    check("rst_result_od", 32'(result_od), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < MAXM; k++) mv[k] = 16'($urandom);
    mv[0] = 16'h1234; mv[1] = 16'hABCD;
    for (int k = 0; k < MAXM; k++) begin
      move_we = 1'b1; move_waddr = 8'(k); move_wd = mv[k];
      tick();
    end
    move_we = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run_frame(vecs[k], 1'b0, 0, 16'h0, k == 3);
      do_reply(vecs[k].rhi, vecs[k].rlo, vecs[k].exp_res);
    end

    // Write colliding with start: this frame sends the old word, the next one the new.
    vc = '{2, 0, 8'h0F, 8'h02, 8'h3E, 8'h7A, 16'h3E7A};
    run_frame(vc, 1'b1, 0, 16'hBEEF, 1'b0);
    do_reply(vc.rhi, vc.rlo, vc.exp_res);
    vc = '{2, 1, 8'hF0, 8'h02, 8'h01, 8'h02, 16'h0102};
    run_frame(vc, 1'b0, 0, 16'h0, 1'b0);
    do_reply(vc.rhi, vc.rlo, vc.exp_res);

    // No reply: timeout after RESP_TIMEOUT cycles in the wait state.
    vc = '{1, 0, 8'h22, 8'h01, 8'h00, 8'h00, 16'h0000};
    run_frame(vc, 1'b0, 0, 16'h0, 1'b0);
    i = 0;
    do begin tick(); i++; end while (s_tmo !== 1'b1 && i < RT + 50);
    check("timeout_cycle", 32'(i - 1), 32'(RT));
    check("timeout_result_kept", 32'(result_od), 32'(last_exp));
    tick();
    check("timeout_single", 32'(s_tmo), 32'd0);

    // Stray reply bytes while idle.
    r0 = res_seen;
    rx_iv = 1'b1; rx_id = 8'h77;
    repeat (3) tick();
    rx_iv = 1'b0;
    repeat (3) tick();
    check("stray_rx_no_result", 32'(res_seen - r0), 32'd0);
    check("stray_rx_result_kept", 32'(result_od), 32'(last_exp));

    // Reset mid-grid, then a clean frame.
    begin_frame(vecs[0], 1'b0, 0, 16'h0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("midrst_busy", 32'(s_busy), 32'd0);
    check("midrst_tx_ov", 32'(s_txov), 32'd0);
    check("midrst_tx_od", 32'(s_txod), 32'd0);
    check("midrst_result_ov", 32'(s_resov), 32'd0);
    check("midrst_timeout", 32'(s_tmo), 32'd0);
    check("midrst_result_od", 32'(result_od), 32'd0);
    exp_q.delete();
    held_vld = 1'b0;
    run_frame(vecs[0], 1'b0, 0, 16'h0, 1'b0);
    do_reply(vecs[0].rhi, vecs[0].rlo, vecs[0].exp_res);

    check("timeout_total", 32'(tmo_seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
